// File: rtl/riscv_biu_arbiter.sv
// ============================================================================
// riscv_biu_arbiter: shares one BIU port between fetch (I) and data (D) sides
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_biu_arbiter #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rstn,

  input  logic                      ibiu_stb_i,
  output logic                      ibiu_stb_ack_o,
  input  logic [PHYS_ADDR_SIZE-1:0] ibiu_adri_i,
  input  logic [XLEN/8-1:0]         ibiu_be_i,
  input  logic [2:0]                ibiu_type_i,
  input  logic                      ibiu_lock_i,
  input  logic                      ibiu_we_i,
  input  logic [XLEN-1:0]           ibiu_di_i,
  input  logic                      ibiu_is_cacheable_i,
  input  logic                      ibiu_is_instruction_i,
  input  logic [1:0]                ibiu_prv_i,
  output logic [PHYS_ADDR_SIZE-1:0] ibiu_adro_o,
  output logic [XLEN-1:0]           ibiu_do_o,
  output logic                      ibiu_rack_o,
  output logic                      ibiu_err_o,

  input  logic                      dbiu_stb_i,
  output logic                      dbiu_stb_ack_o,
  input  logic [PHYS_ADDR_SIZE-1:0] dbiu_adri_i,
  input  logic [XLEN/8-1:0]         dbiu_be_i,
  input  logic [2:0]                dbiu_type_i,
  input  logic                      dbiu_lock_i,
  input  logic                      dbiu_we_i,
  input  logic [XLEN-1:0]           dbiu_di_i,
  input  logic                      dbiu_is_cacheable_i,
  input  logic                      dbiu_is_instruction_i,
  input  logic [1:0]                dbiu_prv_i,
  output logic [PHYS_ADDR_SIZE-1:0] dbiu_adro_o,
  output logic [XLEN-1:0]           dbiu_do_o,
  output logic                      dbiu_rack_o,
  output logic                      dbiu_err_o,

  output logic                      biu_stb_o,
  input  logic                      biu_stb_ack_i,
  output logic [PHYS_ADDR_SIZE-1:0] biu_adri_o,
  output logic [XLEN/8-1:0]         biu_be_o,
  output logic [2:0]                biu_type_o,
  output logic                      biu_lock_o,
  output logic                      biu_we_o,
  output logic [XLEN-1:0]           biu_di_o,
  output logic                      biu_is_cacheable_o,
  output logic                      biu_is_instruction_o,
  output logic [1:0]                biu_prv_o,
  input  logic [PHYS_ADDR_SIZE-1:0] biu_adro_i,
  input  logic [XLEN-1:0]           biu_do_i,
  input  logic                      biu_rack_i,
  input  logic                      biu_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [DEPTH-1:0] own_q;
  logic [4:0]       beats_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lock_vld_q, lock_vld_d;
  logic             lock_own_q, lock_own_d;
  logic             last_gnt_q, last_gnt_d;

  logic             gnt;
  logic             gnt_stb;
  logic             owner_stb;
  logic             full;
  logic             empty;
  logic             accept;
  logic             head_own;
  logic [4:0]       head_beats;
  logic             rsp_rack;
  logic             rsp_err;
  logic             pop;
  logic             dec;

  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      3'd2, 3'd3: burst_beats = 5'd4;
      3'd4, 3'd5: burst_beats = 5'd8;
      3'd6, 3'd7: burst_beats = 5'd16;
      default:    burst_beats = 5'd1;
    endcase
  endfunction

  // With nobody strobing the grant parks on last_grant so request fields stay stable
  always_comb begin
    gnt = last_gnt_q;
    if (lock_vld_q)                    gnt = lock_own_q;
    else if (ibiu_stb_i & ~dbiu_stb_i) gnt = OWN_I;
    else if (dbiu_stb_i & ~ibiu_stb_i) gnt = OWN_D;
    else if (ibiu_stb_i &  dbiu_stb_i) gnt = ~last_gnt_q;
  end

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign gnt_stb = (gnt == OWN_D) ? dbiu_stb_i : ibiu_stb_i;

  assign biu_stb_o            = rstn & gnt_stb & ~full;
  assign biu_adri_o           = (gnt == OWN_D) ? dbiu_adri_i           : ibiu_adri_i;
  assign biu_be_o             = (gnt == OWN_D) ? dbiu_be_i             : ibiu_be_i;
  assign biu_type_o           = (gnt == OWN_D) ? dbiu_type_i           : ibiu_type_i;
  assign biu_lock_o           = (gnt == OWN_D) ? dbiu_lock_i           : ibiu_lock_i;
  assign biu_we_o             = (gnt == OWN_D) ? dbiu_we_i             : ibiu_we_i;
  assign biu_di_o             = (gnt == OWN_D) ? dbiu_di_i             : ibiu_di_i;
  assign biu_is_cacheable_o   = (gnt == OWN_D) ? dbiu_is_cacheable_i   : ibiu_is_cacheable_i;
  assign biu_is_instruction_o = (gnt == OWN_D) ? dbiu_is_instruction_i : ibiu_is_instruction_i;
  assign biu_prv_o            = (gnt == OWN_D) ? dbiu_prv_i            : ibiu_prv_i;

  assign accept         = biu_stb_o & biu_stb_ack_i;
  assign ibiu_stb_ack_o = accept & (gnt == OWN_I);
  assign dbiu_stb_ack_o = accept & (gnt == OWN_D);

  assign head_own   = own_q[rd_ptr_q];
  assign head_beats = beats_q[rd_ptr_q];
  assign rsp_rack   = biu_rack_i & ~empty;
  assign rsp_err    = biu_err_i  & ~empty;
  // An error retires the whole transaction, whatever beats remain
  assign pop        = rsp_err | (rsp_rack & (head_beats == 5'd1));
  assign dec        = rsp_rack & ~pop;

  assign ibiu_adro_o = biu_adro_i;
  assign dbiu_adro_o = biu_adro_i;
  assign ibiu_do_o   = biu_do_i;
  assign dbiu_do_o   = biu_do_i;
  assign ibiu_rack_o = rsp_rack & (head_own == OWN_I);
  assign ibiu_err_o  = rsp_err  & (head_own == OWN_I);
  assign dbiu_rack_o = rsp_rack & (head_own == OWN_D);
  assign dbiu_err_o  = rsp_err  & (head_own == OWN_D);

  assign owner_stb = (lock_own_q == OWN_D) ? dbiu_stb_i : ibiu_stb_i;

  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q;
    if (accept & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (pop & ~accept) cnt_d = cnt_q - 1'b1;
    last_gnt_d = accept ? gnt : last_gnt_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (accept) begin
      lock_vld_d = biu_lock_o;
      lock_own_d = gnt;
    end else if (lock_vld_q & ~owner_stb) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      own_q      <= '0;
      for (int i = 0; i < DEPTH; i++) beats_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= OWN_I;
      last_gnt_q <= OWN_I;
    end else begin
      // accept never targets the head slot: it needs !full, dec needs !empty
      if (accept) begin
        own_q[wr_ptr_q]   <= gnt;
        beats_q[wr_ptr_q] <= burst_beats(biu_type_o);
      end
      if (dec) beats_q[rd_ptr_q] <= head_beats - 5'd1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_biu_arbiter.sv
// ============================================================================
// tb_riscv_biu_arbiter: scoreboard bench with a transaction-queue reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_biu_arbiter;

  localparam int XLEN  = 32;
  localparam int PA    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            ibiu_stb_i, ibiu_stb_ack_o, ibiu_lock_i, ibiu_we_i, ibiu_is_cacheable_i, ibiu_is_instruction_i;
  logic [PA-1:0]   ibiu_adri_i, ibiu_adro_o;
  logic [3:0]      ibiu_be_i;
  logic [2:0]      ibiu_type_i;
  logic [XLEN-1:0] ibiu_di_i, ibiu_do_o;
  logic [1:0]      ibiu_prv_i;
  logic            ibiu_rack_o, ibiu_err_o;
  logic            dbiu_stb_i, dbiu_stb_ack_o, dbiu_lock_i, dbiu_we_i, dbiu_is_cacheable_i, dbiu_is_instruction_i;
  logic [PA-1:0]   dbiu_adri_i, dbiu_adro_o;
  logic [3:0]      dbiu_be_i;
  logic [2:0]      dbiu_type_i;
  logic [XLEN-1:0] dbiu_di_i, dbiu_do_o;
  logic [1:0]      dbiu_prv_i;
  logic            dbiu_rack_o, dbiu_err_o;
  logic            biu_stb_o, biu_stb_ack_i, biu_lock_o, biu_we_o, biu_is_cacheable_o, biu_is_instruction_o;
  logic [PA-1:0]   biu_adri_o, biu_adro_i;
  logic [3:0]      biu_be_o;
  logic [2:0]      biu_type_o;
  logic [XLEN-1:0] biu_di_o, biu_do_i;
  logic [1:0]      biu_prv_o;
  logic            biu_rack_i, biu_err_i;

  riscv_biu_arbiter #(.XLEN(XLEN), .PHYS_ADDR_SIZE(PA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ibiu_stb_i(ibiu_stb_i), .ibiu_stb_ack_o(ibiu_stb_ack_o), .ibiu_adri_i(ibiu_adri_i),
    .ibiu_be_i(ibiu_be_i), .ibiu_type_i(ibiu_type_i), .ibiu_lock_i(ibiu_lock_i), .ibiu_we_i(ibiu_we_i),
    .ibiu_di_i(ibiu_di_i), .ibiu_is_cacheable_i(ibiu_is_cacheable_i),
    .ibiu_is_instruction_i(ibiu_is_instruction_i), .ibiu_prv_i(ibiu_prv_i),
    .ibiu_adro_o(ibiu_adro_o), .ibiu_do_o(ibiu_do_o), .ibiu_rack_o(ibiu_rack_o), .ibiu_err_o(ibiu_err_o),
    .dbiu_stb_i(dbiu_stb_i), .dbiu_stb_ack_o(dbiu_stb_ack_o), .dbiu_adri_i(dbiu_adri_i),
    .dbiu_be_i(dbiu_be_i), .dbiu_type_i(dbiu_type_i), .dbiu_lock_i(dbiu_lock_i), .dbiu_we_i(dbiu_we_i),
    .dbiu_di_i(dbiu_di_i), .dbiu_is_cacheable_i(dbiu_is_cacheable_i),
    .dbiu_is_instruction_i(dbiu_is_instruction_i), .dbiu_prv_i(dbiu_prv_i),
    .dbiu_adro_o(dbiu_adro_o), .dbiu_do_o(dbiu_do_o), .dbiu_rack_o(dbiu_rack_o), .dbiu_err_o(dbiu_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_adri_o(biu_adri_o), .biu_be_o(biu_be_o),
    .biu_type_o(biu_type_o), .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_di_o(biu_di_o),
    .biu_is_cacheable_o(biu_is_cacheable_o), .biu_is_instruction_o(biu_is_instruction_o),
    .biu_prv_o(biu_prv_o), .biu_adro_i(biu_adro_i), .biu_do_i(biu_do_i),
    .biu_rack_i(biu_rack_i), .biu_err_i(biu_err_i)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // Beats per HBURST: SINGLE/INCR are one beat, then 4/8/16 for each pair
  function automatic int beats_of(input logic [2:0] t);
    return (t < 3'd2) ? 1 : (2 << (t >> 1));
  endfunction

  // Reference model: ordered list of outstanding transactions plus arbitration memory
  typedef struct { logic own; int rem; } txn_t;
  txn_t sb[$];
  logic m_last = 1'b0, m_lock_v = 1'b0, m_lock_o = 1'b0;
  logic n_last, n_lock_v, n_lock_o;
  logic p_valid = 1'b0, p_push = 1'b0, p_own = 1'b0, p_pop = 1'b0, p_dec = 1'b0;
  int   p_beats = 0;

  logic g, gstb, ebs, acc, req_lock;

  always @(negedge clk) begin : req_side
    if (rstn) begin
      if (m_lock_v)                   g = m_lock_o;
      else if (ibiu_stb_i ^ dbiu_stb_i) g = dbiu_stb_i;
      else if (ibiu_stb_i & dbiu_stb_i) g = ~m_last;
      else                            g = m_last;
      gstb = g ? dbiu_stb_i : ibiu_stb_i;
      ebs  = gstb && (sb.size() < DEPTH);
      acc  = ebs & biu_stb_ack_i;
      chk("biu_stb", 64'(biu_stb_o), 64'(ebs));
      chk("stb_ack", {ibiu_stb_ack_o, dbiu_stb_ack_o}, {acc & ~g, acc & g});
      chk("req_ctl",
          {biu_adri_o, biu_type_o, biu_we_o, biu_lock_o, biu_be_o, biu_is_cacheable_o, biu_is_instruction_o, biu_prv_o},
          g ? {dbiu_adri_i, dbiu_type_i, dbiu_we_i, dbiu_lock_i, dbiu_be_i, dbiu_is_cacheable_i, dbiu_is_instruction_i, dbiu_prv_i}
            : {ibiu_adri_i, ibiu_type_i, ibiu_we_i, ibiu_lock_i, ibiu_be_i, ibiu_is_cacheable_i, ibiu_is_instruction_i, ibiu_prv_i});
      chk("req_data", 64'(biu_di_o), 64'(g ? dbiu_di_i : ibiu_di_i));
      req_lock = g ? dbiu_lock_i : ibiu_lock_i;
      p_push  = acc;
      p_own   = g;
      p_beats = beats_of(g ? dbiu_type_i : ibiu_type_i);
      n_last  = acc ? g : m_last;
      n_lock_o = m_lock_o;
      n_lock_v = m_lock_v;
      if (acc) begin
        n_lock_v = req_lock;
        n_lock_o = g;
      end else if (m_lock_v && !(m_lock_o ? dbiu_stb_i : ibiu_stb_i)) begin
        n_lock_v = 1'b0;
      end
      p_valid = 1'b1;
    end
  end

  logic [3:0] exp_rsp;

  always @(negedge clk) begin : rsp_side
    if (rstn) begin
      if (sb.size() == 0) exp_rsp = 4'b0000;
      else if (sb[0].own) exp_rsp = {2'b00, biu_rack_i, biu_err_i};
      else                exp_rsp = {biu_rack_i, biu_err_i, 2'b00};
      chk("rsp_route", {ibiu_rack_o, ibiu_err_o, dbiu_rack_o, dbiu_err_o}, exp_rsp);
      if (biu_rack_i | biu_err_i) begin
        chk("rsp_data", {ibiu_do_o, dbiu_do_o}, {biu_do_i, biu_do_i});
        chk("rsp_adr", {ibiu_adro_o, dbiu_adro_o}, {biu_adro_i, biu_adro_i});
      end
      p_pop = (sb.size() != 0) && (biu_err_i || (biu_rack_i && sb[0].rem == 1));
      p_dec = (sb.size() != 0) && biu_rack_i && !p_pop;
    end else begin
      chk("rst_outs", {biu_stb_o, ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_rack_o, ibiu_err_o, dbiu_rack_o, dbiu_err_o}, 0);
    end
  end

  task automatic model_clear();
    sb.delete();
    m_last = 1'b0; m_lock_v = 1'b0; m_lock_o = 1'b0;
    p_valid = 1'b0; p_push = 1'b0; p_pop = 1'b0; p_dec = 1'b0;
  endtask

  always @(negedge rstn) model_clear();

  always @(posedge clk) begin
    if (!rstn) model_clear();
    else if (p_valid) begin
      if (p_pop) void'(sb.pop_front());
      else if (p_dec) sb[0].rem = sb[0].rem - 1;
      if (p_push) sb.push_back('{own: p_own, rem: p_beats});
      m_last = n_last; m_lock_v = n_lock_v; m_lock_o = n_lock_o;
      p_valid = 1'b0; p_push = 1'b0; p_pop = 1'b0; p_dec = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ibiu_stb_i = 0; dbiu_stb_i = 0; ibiu_lock_i = 0; dbiu_lock_i = 0;
    ibiu_type_i = 0; dbiu_type_i = 0; biu_rack_i = 0; biu_err_i = 0; biu_stb_ack_i = 1;
  endtask

  task automatic rand_fields();
    ibiu_adri_i = $urandom; dbiu_adri_i = $urandom; ibiu_di_i = $urandom; dbiu_di_i = $urandom;
    ibiu_be_i = 4'($urandom); dbiu_be_i = 4'($urandom); ibiu_we_i = 1'($urandom); dbiu_we_i = 1'($urandom);
    ibiu_is_cacheable_i = 1'($urandom); dbiu_is_cacheable_i = 1'($urandom);
    ibiu_is_instruction_i = 1'($urandom); dbiu_is_instruction_i = 1'($urandom);
    ibiu_prv_i = 2'($urandom); dbiu_prv_i = 2'($urandom);
    biu_adro_i = $urandom; biu_do_i = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rand_fields();
    ibiu_adri_i = 32'h8000_0000; dbiu_adri_i = 32'h0000_1000;
    ibiu_stb_i = 1; biu_rack_i = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    idle();

    // Lone I single, then its one beat
    ibiu_stb_i = 1; tick();
    ibiu_stb_i = 0; biu_rack_i = 1; biu_do_i = 32'h0000_0013; tick();
    biu_rack_i = 0; tick();

    // Both strobing: alternate D,I,D,I, then full; one rack frees a slot
    ibiu_stb_i = 1; dbiu_stb_i = 1;
    repeat (5) tick();
    biu_rack_i = 1; tick();
    biu_rack_i = 0; tick();
    idle(); biu_rack_i = 1;
    repeat (6) tick();
    idle();

    // D INCR4 then I single: four beats to D, the fifth to I
    dbiu_stb_i = 1; dbiu_type_i = 3'd3; tick();
    idle(); ibiu_stb_i = 1; tick();
    idle(); biu_rack_i = 1;
    repeat (5) tick();
    idle();

    // Locked D sequence starves I until D releases the lock
    ibiu_stb_i = 1; dbiu_stb_i = 1; dbiu_lock_i = 1; biu_rack_i = 1;
    repeat (3) tick();
    dbiu_lock_i = 0; tick();
    tick();
    idle(); biu_rack_i = 1;
    repeat (5) tick();
    idle();

    // D WRAP8 errors on beat 3, then an I single takes the next rack
    dbiu_stb_i = 1; dbiu_type_i = 3'd4; tick();
    idle(); biu_rack_i = 1; repeat (2) tick();
    biu_rack_i = 0; biu_err_i = 1; tick();
    idle(); ibiu_stb_i = 1; tick();
    idle(); biu_rack_i = 1; tick();
    idle();

    // Async reset with transactions outstanding, then a stray rack
    ibiu_stb_i = 1; repeat (3) tick();
    biu_rack_i = 1;
    @(posedge clk);
    #3 rstn = 0;
    #1 chk("async_rst",
           {biu_stb_o, ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_rack_o, ibiu_err_o, dbiu_rack_o, dbiu_err_o}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    idle(); biu_rack_i = 1; tick();
    idle(); tick();

    for (int c = 0; c < 1500; c++) begin
      rand_fields();
      ibiu_stb_i    = 1'($urandom);
      dbiu_stb_i    = 1'($urandom);
      ibiu_type_i   = 3'($urandom);
      dbiu_type_i   = 3'($urandom);
      ibiu_lock_i   = ($urandom_range(0, 7) == 0);
      dbiu_lock_i   = ($urandom_range(0, 7) == 0);
      biu_stb_ack_i = ($urandom_range(0, 3) != 0);
      biu_rack_i    = 1'($urandom);
      biu_err_i     = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
